// File: rtl/imem_arbiter_pkg.sv
// Shared encodings and bus widths for the instruction-memory arbiter.
// Optional performance counters are enabled by defining IMEM_ARB_PERF_EN.
package imem_arbiter_pkg;

    localparam int IMEM_ADDR_BUS_W = 14;
    localparam int INSTR_BUS_W     = 32;
    localparam int WAIT_CNT_W      = 4;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic ARB_ST_IF_PRI  = 1'b0;
    localparam logic ARB_ST_DBG_PRI = 1'b1;

    typedef enum logic {
        ST_IF_PRI  = ARB_ST_IF_PRI,
        ST_DBG_PRI = ARB_ST_DBG_PRI
    } arb_state_e;

endpackage

// File: rtl/imem_rsp_reg.sv
// Valid/data holding register for one requester's ROM response.
// A load wins over consume/flush, so a same-cycle flush+load keeps the new word.
module imem_rsp_reg
    import imem_arbiter_pkg::*;
#(
    parameter int W = INSTR_BUS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         consume,
    input  logic         flush,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (consume || flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the combinational instruction ROM between fetch (IF) and debug (DBG).
// Define IMEM_ARB_PERF_EN to add perf_if_gnt / perf_dbg_gnt / perf_conflict counters.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = IMEM_ADDR_BUS_W,
    parameter int DATA_W       = INSTR_BUS_W,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_instr,
    input  logic              if_rsp_ready,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_instr,
    output logic              arb_state
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_gnt,
    output logic [31:0]       perf_dbg_gnt,
    output logic [31:0]       perf_conflict
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_THRESH = WAIT_CNT_W'(DBG_MAX_WAIT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_SAT    = '1;

    arb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  if_elig, dbg_elig, if_win, dbg_win;

    always_comb begin
        if_elig  = if_req & (~if_rsp_valid | if_rsp_ready | if_flush);
        dbg_elig = dbg_req;
        if_win   = 1'b0;
        dbg_win  = 1'b0;
        // Grants are forced low while reset is held.
        if (rst) begin
            if (state_q == ST_DBG_PRI) begin
                dbg_win = dbg_elig;
                if_win  = if_elig & ~dbg_elig;
            end else begin
                if_win  = if_elig;
                dbg_win = dbg_elig & ~if_elig;
            end
        end
    end

    always_comb begin
        if_gnt   = if_win;
        dbg_gnt  = dbg_win;
        rom_ce   = CHIP_DISABLE;
        rom_addr = '0;
        if (if_win) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = if_addr;
        end else if (dbg_win) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = dbg_addr;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        state_d    = state_q;
        if (dbg_req && !dbg_win) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        case (state_q)
            ST_IF_PRI: begin
                if (dbg_req && !dbg_win && wait_cnt_d >= WAIT_THRESH) state_d = ST_DBG_PRI;
            end
            ST_DBG_PRI: begin
                if (dbg_win || !dbg_req) state_d = ST_IF_PRI;
            end
            default: state_d = ST_IF_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IF_PRI;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign arb_state = state_q;

    imem_rsp_reg #(.W(DATA_W)) u_if_rsp (
        .clk       (clk),
        .rst       (rst),
        .load      (if_win),
        .load_data (rom_instr),
        .consume   (if_rsp_ready),
        .flush     (if_flush),
        .valid     (if_rsp_valid),
        .data      (if_rsp_instr)
    );

    // DBG has no backpressure: the response is a one-cycle pulse, data held until reload.
    imem_rsp_reg #(.W(DATA_W)) u_dbg_rsp (
        .clk       (clk),
        .rst       (rst),
        .load      (dbg_win),
        .load_data (rom_instr),
        .consume   (1'b1),
        .flush     (1'b0),
        .valid     (dbg_rsp_valid),
        .data      (dbg_rsp_data)
    );

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_if_gnt_q, perf_if_gnt_d;
    logic [31:0] perf_dbg_gnt_q, perf_dbg_gnt_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    always_comb begin
        perf_if_gnt_d   = perf_if_gnt_q + {31'd0, if_win};
        perf_dbg_gnt_d  = perf_dbg_gnt_q + {31'd0, dbg_win};
        perf_conflict_d = perf_conflict_q + {31'd0, if_elig & dbg_elig};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_gnt_q   <= '0;
            perf_dbg_gnt_q  <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_if_gnt_q   <= perf_if_gnt_d;
            perf_dbg_gnt_q  <= perf_dbg_gnt_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_if_gnt   = perf_if_gnt_q;
    assign perf_dbg_gnt  = perf_dbg_gnt_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and an expected-response queue.
module tb_imem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_gnt, if_flush, if_rsp_valid, if_rsp_ready;
    logic [ADDR_W-1:0] if_addr, dbg_addr, rom_addr;
    logic [DATA_W-1:0] if_rsp_instr, dbg_rsp_data, rom_instr;
    logic              dbg_req, dbg_gnt, dbg_rsp_valid, rom_ce, arb_state;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0]       perf_if_gnt, perf_dbg_gnt, perf_conflict;
`endif

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    // Behavioural ROM: 64 words populated, everything above 0xff reads as zero.
    assign rom_instr = (rom_addr < 14'h0100) ? mem[rom_addr[7:2]] : '0;

    imem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_flush      (if_flush),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_instr  (if_rsp_instr),
        .if_rsp_ready  (if_rsp_ready),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_gnt       (dbg_gnt),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_data  (dbg_rsp_data),
        .rom_addr      (rom_addr),
        .rom_ce        (rom_ce),
        .rom_instr     (rom_instr),
        .arb_state     (arb_state)
`ifdef IMEM_ARB_PERF_EN
        ,
        .perf_if_gnt   (perf_if_gnt),
        .perf_dbg_gnt  (perf_dbg_gnt),
        .perf_conflict (perf_conflict)
`endif
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return (a < 14'h0100) ? mem[a[7:2]] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req       = 1'b0;
        if_addr      = '0;
        if_flush     = 1'b0;
        if_rsp_ready = 1'b1;
        dbg_req      = 1'b0;
        dbg_addr     = '0;
    endtask

    task automatic init_rom();
        for (int i = 0; i < 64; i++) mem[i] = (32'h9e3779b9 * (i + 1)) ^ 32'h00a5_1234;
        mem[0]  = 32'hffe18113;
        mem[1]  = 32'hfff18a13;
        mem[2]  = 32'h00318a93;
        mem[4]  = 32'h01412b33;
        mem[30] = 32'h008003ef;
        mem[37] = 32'h0a028367;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b1; dbg_req = 1'b1; if_addr = 14'h0004; dbg_addr = 14'h0078;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_gnt, dbg_gnt, rom_ce, rom_addr} !== 17'd0)
            begin errors++; $display("FAIL reset_comb: gnt/ce/addr=%h expected 0", {if_gnt, dbg_gnt, rom_ce, rom_addr}); end
        checks++;
        if ({if_rsp_valid, dbg_rsp_valid, if_rsp_instr, dbg_rsp_data} !== 66'd0)
            begin errors++; $display("FAIL reset_rsp: valid=%b%b instr=%h data=%h expected all 0", if_rsp_valid, dbg_rsp_valid, if_rsp_instr, dbg_rsp_data); end
        idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_stream();
        logic [DATA_W-1:0] want [3];
        want[0] = 32'hffe18113; want[1] = 32'hfff18a13; want[2] = 32'h00318a93;
        if_req = 1'b1; if_rsp_ready = 1'b1; if_addr = 14'h0000;
        @(negedge clk);
        checks++;
        if ({if_gnt, dbg_gnt, rom_ce, rom_addr} !== {1'b1, 1'b0, 1'b1, 14'h0000})
            begin errors++; $display("FAIL stream_first_gnt: got %h expected %h", {if_gnt, dbg_gnt, rom_ce, rom_addr}, {1'b1, 1'b0, 1'b1, 14'h0000}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i < 3) if_addr = 14'(i * 4); else if_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({if_rsp_valid, if_rsp_instr} !== {1'b1, want[i-1]})
                begin errors++; $display("FAIL stream_rsp%0d: valid=%b instr=%h expected 1 %h", i - 1, if_rsp_valid, if_rsp_instr, want[i-1]); end
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b0)
            begin errors++; $display("FAIL stream_drain: valid=%b expected 0", if_rsp_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        if_req = 1'b1; if_addr = 14'h000c; if_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL bp_first_gnt: if_gnt=%b expected 1", if_gnt); end
        tick();
        if_addr = 14'h0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt, if_rsp_valid, if_rsp_instr} !== {1'b0, 1'b1, rom_word(14'h000c)})
                begin errors++; $display("FAIL bp_hold%0d: gnt=%b valid=%b instr=%h expected 0 1 %h", k, if_gnt, if_rsp_valid, if_rsp_instr, rom_word(14'h000c)); end
            tick();
        end
        if_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_gnt, rom_addr, if_rsp_instr} !== {1'b1, 14'h0010, rom_word(14'h000c)})
            begin errors++; $display("FAIL bp_release: gnt=%b addr=%h instr=%h expected 1 0010 %h", if_gnt, rom_addr, if_rsp_instr, rom_word(14'h000c)); end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rsp_valid, if_rsp_instr} !== {1'b1, 32'h01412b33})
            begin errors++; $display("FAIL bp_next: valid=%b instr=%h expected 1 01412b33", if_rsp_valid, if_rsp_instr); end
        tick();
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 14'h0010; if_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_setup_gnt: if_gnt=%b expected 1", if_gnt); end
        tick();
        if_addr = 14'h0094; if_flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_gnt, rom_addr, if_rsp_valid, if_rsp_instr} !== {1'b1, 14'h0094, 1'b1, 32'h01412b33})
            begin errors++; $display("FAIL flush_gnt: gnt=%b addr=%h valid=%b instr=%h expected 1 0094 1 01412b33", if_gnt, rom_addr, if_rsp_valid, if_rsp_instr); end
        tick();
        if_flush = 1'b0; if_req = 1'b0; if_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_rsp_valid, if_rsp_instr} !== {1'b1, 32'h0a028367})
            begin errors++; $display("FAIL flush_new: valid=%b instr=%h expected 1 0a028367", if_rsp_valid, if_rsp_instr); end
        tick();
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_drain: valid=%b expected 0", if_rsp_valid); end
        tick();
    endtask

    task automatic test_starvation();
        if_req = 1'b1; if_rsp_ready = 1'b1; dbg_req = 1'b1; dbg_addr = 14'h0078;
        for (int c = 1; c <= 5; c++) begin
            if_addr = 14'(14'h0020 + 4 * c);
            @(negedge clk);
            checks++;
            if (c == 4) begin
                if ({if_gnt, dbg_gnt, rom_addr} !== {1'b0, 1'b1, 14'h0078})
                    begin errors++; $display("FAIL starve_cycle%0d: if/dbg=%b%b addr=%h expected 01 0078", c, if_gnt, dbg_gnt, rom_addr); end
            end else begin
                if ({if_gnt, dbg_gnt, rom_addr} !== {1'b1, 1'b0, if_addr})
                    begin errors++; $display("FAIL starve_cycle%0d: if/dbg=%b%b addr=%h expected 10 %h", c, if_gnt, dbg_gnt, rom_addr, if_addr); end
            end
            if (c == 5) begin
                checks++;
                if ({dbg_rsp_valid, dbg_rsp_data} !== {1'b1, 32'h008003ef})
                    begin errors++; $display("FAIL starve_dbg_rsp: valid=%b data=%h expected 1 008003ef", dbg_rsp_valid, dbg_rsp_data); end
            end
            tick();
        end
        dbg_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({dbg_rsp_valid, dbg_rsp_data} !== {1'b0, 32'h008003ef})
            begin errors++; $display("FAIL starve_pulse: valid=%b data=%h expected 0 008003ef", dbg_rsp_valid, dbg_rsp_data); end
        tick();
    endtask

    task automatic test_out_of_range();
        if_req = 1'b1; if_rsp_ready = 1'b1; if_addr = 14'h0004;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL oor_setup_gnt: if_gnt=%b expected 1", if_gnt); end
        tick();
        if_addr = 14'h3ffc;
        @(negedge clk);
        checks++;
        if ({if_gnt, rom_ce, rom_addr, if_rsp_valid, if_rsp_instr} !== {1'b1, 1'b1, 14'h3ffc, 1'b1, 32'hfff18a13})
            begin errors++; $display("FAIL oor_gnt: gnt=%b ce=%b addr=%h valid=%b instr=%h expected 1 1 3ffc 1 fff18a13", if_gnt, rom_ce, rom_addr, if_rsp_valid, if_rsp_instr); end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rsp_valid, if_rsp_instr} !== {1'b1, 32'h0})
            begin errors++; $display("FAIL oor_rsp: valid=%b instr=%h expected 1 00000000", if_rsp_valid, if_rsp_instr); end
        tick();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 14'h0008; if_rsp_ready = 1'b0;
        @(negedge clk);
        tick();
        if_req = 1'b0; dbg_req = 1'b1; dbg_addr = 14'h0078;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rmid_dbg_gnt: dbg_gnt=%b expected 1", dbg_gnt); end
        tick();
        if_req = 1'b1;
        #2;
        checks++;
        if ({if_rsp_valid, dbg_rsp_valid} !== 2'b11)
            begin errors++; $display("FAIL rmid_pre: valids=%b%b expected 11", if_rsp_valid, dbg_rsp_valid); end
        rst = 1'b0;
        #1;
        checks++;
        if ({if_rsp_valid, dbg_rsp_valid, if_rsp_instr, dbg_rsp_data} !== 66'd0)
            begin errors++; $display("FAIL rmid_drop: valids=%b%b instr=%h data=%h expected all 0", if_rsp_valid, dbg_rsp_valid, if_rsp_instr, dbg_rsp_data); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt, dbg_gnt, rom_ce, rom_addr} !== 17'd0)
                begin errors++; $display("FAIL rmid_held%0d: gnt/ce/addr=%h expected 0", k, {if_gnt, dbg_gnt, rom_ce, rom_addr}); end
        end
        idle();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({if_rsp_valid, dbg_rsp_valid} !== 2'b00)
            begin errors++; $display("FAIL rmid_no_replay: valids=%b%b expected 00", if_rsp_valid, dbg_rsp_valid); end
        tick();
    endtask

`ifdef IMEM_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            if_rsp_ready = 1'b1;
            if_req  = (c <= 2) || (c >= 5);
            dbg_req = (c <= 4);
            if_addr = 14'(4 * c); dbg_addr = 14'h0078;
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if ({perf_if_gnt, perf_dbg_gnt, perf_conflict} !== {32'd5, 32'd2, 32'd2})
            begin errors++; $display("FAIL perf_counts: if=%0d dbg=%0d conflict=%0d expected 5 2 2", perf_if_gnt, perf_dbg_gnt, perf_conflict); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic              m_valid, m_dbg_valid, m_boost, if_el, if_w, dbg_w;
        logic [DATA_W-1:0] m_dbg_data, got_word;
        logic [ADDR_W-1:0] e_addr;
        int                m_streak;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        m_valid = 1'b0; m_dbg_valid = 1'b0; m_boost = 1'b0; m_streak = 0; m_dbg_data = '0;
        exp_q.delete();
        for (int n = 0; n < 500; n++) begin
            if_req       = ($urandom_range(0, 9) < 7);
            dbg_req      = ($urandom_range(0, 9) < 5);
            if_rsp_ready = ($urandom_range(0, 9) < 6);
            if_flush     = ($urandom_range(0, 9) == 0);
            if_addr      = 14'($urandom_range(0, 14'h01ff));
            dbg_addr     = 14'($urandom_range(0, 14'h01ff));
            @(negedge clk);
            // Reference: IF first unless DBG has been boosted by a long enough denial streak.
            if_el = if_req && (!m_valid || if_rsp_ready || if_flush);
            if (m_boost) begin
                dbg_w = dbg_req;
                if_w  = if_el && !dbg_req;
            end else begin
                if_w  = if_el;
                dbg_w = dbg_req && !if_el;
            end
            e_addr = if_w ? if_addr : (dbg_w ? dbg_addr : 14'h0);
            checks++;
            if ({if_gnt, dbg_gnt, rom_ce, rom_addr} !== {if_w, dbg_w, if_w | dbg_w, e_addr})
                begin errors++; $display("FAIL rand_grant@%0d: if/dbg/ce=%b%b%b addr=%h expected %b%b%b %h", n, if_gnt, dbg_gnt, rom_ce, rom_addr, if_w, dbg_w, if_w | dbg_w, e_addr); end
            checks++;
            if ({if_rsp_valid, dbg_rsp_valid} !== {m_valid, m_dbg_valid})
                begin errors++; $display("FAIL rand_valid@%0d: if/dbg valid=%b%b expected %b%b", n, if_rsp_valid, dbg_rsp_valid, m_valid, m_dbg_valid); end
            if (m_dbg_valid) begin
                checks++;
                if (dbg_rsp_data !== m_dbg_data)
                    begin errors++; $display("FAIL rand_dbg_data@%0d: data=%h expected %h", n, dbg_rsp_data, m_dbg_data); end
            end
            if (if_flush) begin
                exp_q.delete();
            end else if (if_rsp_valid && if_rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_if_unexpected@%0d: instr=%h with no expected response", n, if_rsp_instr);
                end else begin
                    got_word = exp_q.pop_front();
                    if (if_rsp_instr !== got_word)
                        begin errors++; $display("FAIL rand_if_data@%0d: instr=%h expected %h", n, if_rsp_instr, got_word); end
                end
            end
            if (if_w) exp_q.push_back(rom_word(if_addr));
            if (if_w) m_valid = 1'b1;
            else if (if_rsp_ready || if_flush) m_valid = 1'b0;
            m_dbg_valid = dbg_w;
            if (dbg_w) m_dbg_data = rom_word(dbg_addr);
            if (dbg_req && !dbg_w) begin
                m_streak = (m_streak < 15) ? m_streak + 1 : 15;
                if (m_streak >= MAXW - 1) m_boost = 1'b1;
            end else begin
                m_streak = 0;
                m_boost  = 1'b0;
            end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        init_rom();
        idle();
        test_reset();
        test_if_stream();
        test_backpressure();
        test_flush();
        test_starvation();
        test_out_of_range();
        test_reset_mid();
`ifdef IMEM_ARB_PERF_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
